note_source_arbiter: RTL and testbench
======================================

// Module: note_source_arbiter
// PURPOSE
//   Shares the single tone generator between two note sources: live keyboard (scanner's debounced
//   key_is_pressed/active_key_id) and the automatic song player. Live play always has priority
//   and preempts the player. Between live notes it inserts a short silent articulation gap so
//   repeated notes retrigger audibly. It holds ownership for a linger window after release so
//   the player cannot grab the generator between rapid key presses. Sits between scanner/player
//   and the tone generator.
// PARAMETERS
//   NOTE_W           4           note ID width; 0 = no note, 1..2^NOTE_W-1 = note IDs
//   GAP_CYCLES       50000       silent articulation gap length in clk cycles (1 ms @ 50 MHz), >= 1
//   LIVE_HOLD_CYCLES 25000000    live-ownership linger after key release (500 ms @ 50 MHz), >= 1
//   CNT_W            derived     $clog2(max(GAP_CYCLES, LIVE_HOLD_CYCLES) + 1), localparam
// PORTS
//   clk              in   1       system clock (50 MHz)
//   rst              in   1       asynchronous reset, active high
//   live_pressed     in   1       debounced "any key pressed" from scanner
//   live_note        in   NOTE_W  debounced active key ID from scanner
//   play_req         in   1       player requests the generator (level; hold for whole song)
//   play_note        in   NOTE_W  player's current note
//   play_note_valid  in   1       player note sounding (0 = rest)
//   play_grant       out  1       player currently owns the generator
//   play_preempt     out  1       one-cycle pulse: player ownership revoked by live input
//   note_out         out  NOTE_W  note to tone generator
//   note_on          out  1       tone generator enable
//   src_live         out  1       generator owned by live keyboard (LIVE, GAP or HOLD)
// BEHAVIOUR
//   - Live is active only when live_pressed==1 AND live_note!=0; otherwise it is treated as released.
//   - All outputs are registered. A decision on inputs sampled at edge N is visible after edge N.
//   - rst (async): state=IDLE, counter=0, all outputs 0 immediately; no clock needed. Applies mid-note too.
//   - FSM states: IDLE, LIVE, GAP, HOLD, PLAY. One down-counter cnt is shared by GAP and HOLD.
//   - IDLE: outputs 0. Live active -> LIVE (note_out=live_note, note_on=1, src_live=1).
//       Else play_req -> PLAY (play_grant=1). If both happen in the same cycle, live wins and there is no preempt pulse.
//   - LIVE: note_out tracks the latched note, note_on=1.
//       Live active with a different live_note -> GAP (cnt=GAP_CYCLES, note_on=0); the new note is latched at GAP exit.
//       Live inactive -> HOLD (cnt=LIVE_HOLD_CYCLES, note_on=0, note_out held).
//   - GAP: note_on=0 for exactly GAP_CYCLES cycles, note_out held, src_live=1, and live input changes do not abort it.
//       At expiry: live active -> LIVE using the current live_note. Otherwise -> HOLD (cnt reloaded).
//   - HOLD: note_on=0, src_live=1. Live active -> LIVE next cycle with no gap (the output is already silent).
//       cnt reaches 0 -> IDLE. play_req is ignored throughout HOLD, and IDLE re-arbitrates on the following cycle.
//   - PLAY: note_out=play_note, note_on=play_note_valid, play_grant=1.
//       play_req low -> IDLE (play_grant=0, note_on=0).
//       Live active -> GAP: play_grant=0, play_preempt=1 for exactly one cycle, note_on=0, src_live=1.
//       The player is not re-granted until the FSM returns to IDLE.
//   - play_req is ignored in LIVE/GAP/HOLD, and play_note/play_note_valid are ignored unless in PLAY.
//   - cnt decrements once per cycle in GAP/HOLD and never wraps. Loading a count of 1 gives a one-cycle state.
//   - Invariant: play_grant and src_live are never both 1. note_on=1 implies note_out!=0.
// TESTING  (bench params: NOTE_W=4, GAP_CYCLES=4, LIVE_HOLD_CYCLES=10)
//   1. Assert rst mid-PLAY with note 3 sounding -> all outputs 0 before the next clk edge; IDLE after release.
//   2. IDLE, live_pressed=1, live_note=5 -> 1 cycle later note_on=1, note_out=5, src_live=1, play_grant=0.
//   3. Holding 5, live_note->8 -> note_on=0 for exactly 4 cycles with note_out=5, then note_on=1, note_out=8.
//   4. Release, play_req=1, re-press note 2 after 6 cycles -> play_grant stays 0, note_on=1 with note 2 1 cycle later.
//      Release again and hold play_req -> play_grant=1 on cycle 12 after release (10 HOLD + IDLE + PLAY).
//   5. PLAY with play_note=3 valid, live press 7 -> play_preempt one-cycle pulse, play_grant=0, 4 silent cycles, note_out=7.
//   6. IDLE with live press 4 and play_req in the same cycle -> LIVE note 4, no play_grant and no play_preempt.
//      Also: live_pressed=1 with live_note=0 leaves the FSM in IDLE.

Source files
------------

// File: rtl/note_source_arbiter.sv
// rtl/note_source_arbiter.sv - live keyboard / song player arbitration for the single tone generator
module note_source_arbiter #(
    parameter int NOTE_W           = 4,
    parameter int GAP_CYCLES       = 50000,
    parameter int LIVE_HOLD_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              live_pressed,
    input  logic [NOTE_W-1:0] live_note,
    input  logic              play_req,
    input  logic [NOTE_W-1:0] play_note,
    input  logic              play_note_valid,
    output logic              play_grant,
    output logic              play_preempt,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_on,
    output logic              src_live
);
    localparam int MAX_CNT = (GAP_CYCLES > LIVE_HOLD_CYCLES) ? GAP_CYCLES : LIVE_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LIVE_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIVE,
        S_GAP,
        S_HOLD,
        S_PLAY
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_play_grant;
    logic              r_play_preempt;
    logic [NOTE_W-1:0] r_note_out;
    logic              r_note_on;
    logic              r_src_live;

    logic w_live_active;
    logic w_play_sounding;
    logic w_cnt_last;

    assign w_live_active   = live_pressed && (live_note != '0);
    // A "valid" rest note of 0 must never enable the generator.
    assign w_play_sounding = play_note_valid && (play_note != '0);
    assign w_cnt_last      = (r_cnt <= CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_play_grant   <= 1'b0;
            r_play_preempt <= 1'b0;
            r_note_out     <= '0;
            r_note_on      <= 1'b0;
            r_src_live     <= 1'b0;
        end else begin
            r_play_preempt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_live_active) begin
                        r_state    <= S_LIVE;
                        r_note_out <= live_note;
                        r_note_on  <= 1'b1;
                        r_src_live <= 1'b1;
                    end else if (play_req) begin
                        r_state      <= S_PLAY;
                        r_play_grant <= 1'b1;
                        r_note_out   <= play_note;
                        r_note_on    <= w_play_sounding;
                    end
                end
                S_LIVE: begin
                    if (!w_live_active) begin
                        r_state   <= S_HOLD;
                        r_cnt     <= HOLD_LOAD;
                        r_note_on <= 1'b0;
                    end else if (live_note != r_note_out) begin
                        r_state   <= S_GAP;
                        r_cnt     <= GAP_LOAD;
                        r_note_on <= 1'b0;
                    end
                end
                S_GAP: begin
                    // The gap always runs to completion; the note is picked at exit.
                    if (w_cnt_last) begin
                        if (w_live_active) begin
                            r_state    <= S_LIVE;
                            r_cnt      <= '0;
                            r_note_out <= live_note;
                            r_note_on  <= 1'b1;
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= HOLD_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (w_live_active) begin
                        r_state    <= S_LIVE;
                        r_cnt      <= '0;
                        r_note_out <= live_note;
                        r_note_on  <= 1'b1;
                    end else if (w_cnt_last) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_note_out <= '0;
                        r_src_live <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_PLAY: begin
                    if (w_live_active) begin
                        r_state        <= S_GAP;
                        r_cnt          <= GAP_LOAD;
                        r_play_grant   <= 1'b0;
                        r_play_preempt <= 1'b1;
                        r_note_on      <= 1'b0;
                        r_src_live     <= 1'b1;
                    end else if (!play_req) begin
                        r_state      <= S_IDLE;
                        r_play_grant <= 1'b0;
                        r_note_out   <= '0;
                        r_note_on    <= 1'b0;
                    end else begin
                        r_note_out <= play_note;
                        r_note_on  <= w_play_sounding;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_play_grant <= 1'b0;
                    r_note_out   <= '0;
                    r_note_on    <= 1'b0;
                    r_src_live   <= 1'b0;
                end
            endcase
        end
    end

    assign play_grant   = r_play_grant;
    assign play_preempt = r_play_preempt;
    assign note_out     = r_note_out;
    assign note_on      = r_note_on;
    assign src_live     = r_src_live;
endmodule

// File: tb/tb_note_source_arbiter.sv
// tb/tb_note_source_arbiter.sv - directed self-checking bench for note_source_arbiter
module tb_note_source_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       live_pressed = 1'b0;
    logic [3:0] live_note = 4'd0;
    logic       play_req = 1'b0;
    logic [3:0] play_note = 4'd0;
    logic       play_note_valid = 1'b0;
    logic       play_grant;
    logic       play_preempt;
    logic [3:0] note_out;
    logic       note_on;
    logic       src_live;

    int n_checks = 0;
    int n_fail   = 0;

    note_source_arbiter #(
        .NOTE_W(4),
        .GAP_CYCLES(4),
        .LIVE_HOLD_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .live_pressed(live_pressed),
        .live_note(live_note),
        .play_req(play_req),
        .play_note(play_note),
        .play_note_valid(play_note_valid),
        .play_grant(play_grant),
        .play_preempt(play_preempt),
        .note_out(note_out),
        .note_on(note_on),
        .src_live(src_live)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("invariant_grant_xor_live", play_grant & src_live, 0);
    endtask

    task automatic check_outs(input string tag, input logic grant, input logic pre,
                              input logic [3:0] nout, input logic non, input logic live);
        check({tag, ".play_grant"}, play_grant, grant);
        check({tag, ".play_preempt"}, play_preempt, pre);
        check({tag, ".note_out"}, note_out, nout);
        check({tag, ".note_on"}, note_on, non);
        check({tag, ".src_live"}, src_live, live);
    endtask

    initial begin
        tick();
        tick();
        check_outs("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_outs("idle_after_reset", 0, 0, 0, 0, 0);

        // 1: async reset while the player is sounding note 3
        play_req = 1; play_note = 3; play_note_valid = 1;
        tick();
        check_outs("t1_play", 1, 0, 3, 1, 0);
        #3 rst = 1'b1;
        #1 check_outs("t1_async_rst", 0, 0, 0, 0, 0);
        play_req = 0; play_note_valid = 0;
        rst = 1'b0;
        tick();
        check_outs("t1_idle", 0, 0, 0, 0, 0);

        // 2: live press of note 5
        live_pressed = 1; live_note = 5;
        tick();
        check_outs("t2_live5", 0, 0, 5, 1, 1);

        // 3: change to note 8 -> four silent gap cycles
        live_note = 8;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs($sformatf("t3_gap%0d", i), 0, 0, 5, 0, 1);
        end
        tick();
        check_outs("t3_live8", 0, 0, 8, 1, 1);

        // 4: release with player waiting, re-press within the hold window
        live_pressed = 0; play_req = 1; play_note = 3; play_note_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_outs($sformatf("t4_hold%0d", i), 0, 0, 8, 0, 1);
        end
        live_pressed = 1; live_note = 2;
        tick();
        check_outs("t4_live2", 0, 0, 2, 1, 1);
        live_pressed = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 10) check($sformatf("t4_hold_live%0d", k), src_live, 1);
            else         check($sformatf("t4_src_live%0d", k), src_live, 0);
            check($sformatf("t4_grant%0d", k), play_grant, (k == 12) ? 1 : 0);
        end
        check_outs("t4_play", 1, 0, 3, 1, 0);

        // 5: live press 7 preempts the player
        live_pressed = 1; live_note = 7;
        tick();
        check_outs("t5_preempt", 0, 1, 3, 0, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_outs($sformatf("t5_gap%0d", i), 0, 0, 3, 0, 1);
        end
        tick();
        check_outs("t5_live7", 0, 0, 7, 1, 1);

        // 6: back to idle, then simultaneous live press and play request
        live_pressed = 0; play_req = 0;
        for (int i = 0; i < 11; i++) tick();
        check_outs("t6_idle", 0, 0, 0, 0, 0);
        live_pressed = 1; live_note = 0;
        tick();
        tick();
        check_outs("t6_note0_idle", 0, 0, 0, 0, 0);
        live_note = 4; play_req = 1;
        tick();
        check_outs("t6_live4", 0, 0, 4, 1, 1);
        tick();
        check_outs("t6_live4_hold", 0, 0, 4, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
